popcount7_reg: RTL and testbench
================================

// Module: popcount7_reg
// PURPOSE
//  - Registered 7-input ones counter: outputs the number of asserted bits on a 7-bit input as a 3-bit binary count (0..7).
//  - Used as a leaf compressor and vote counter in datapath and majority logic; it needs no handshake from its neighbours.
//  - One clock; reset is synchronous and active-high.
// PARAMETERS
//  - none; widths fixed by package constants N_IN=7, CNT_W=3
// PORTS
//  clk    input   1      rising-edge clock
//  rst    input   1      synchronous reset, active-high
//  a      input   [0:6]  data bits; a[0] is bit 0 of the vector, ordering irrelevant to result
//  in_vld input   1      capture strobe; a is sampled only when high
//  w0     output  1      count bit 0 (LSB)
//  w1     output  1      count bit 1
//  w2     output  1      count bit 2 (MSB)
//  out_vld output 1      high one cycle after an accepted sample
// BEHAVIOUR
//  - count = sum of a[0..6], unsigned, range 0..7; never overflows 3 bits; {w2,w1,w0} = count.
//  - Latency 1 cycle: at edge k with in_vld=1, outputs take count(a@k) and out_vld=1.
//  - in_vld=0 at an edge: w2..w0 hold their previous value; out_vld=0.
//  - rst=1 at an edge: w2..w0=3'b000, out_vld=0; rst overrides in_vld in that cycle.
//  - First in_vld after reset release is accepted normally; no dead cycle.
//  - Reset mid-stream discards the pending result; the next accepted sample is unaffected.
//  - Back-to-back in_vld: one result per cycle, no bubbles.
//  - Boundaries: all-zero -> 000; all-ones -> 111; any single bit -> 001.
//  - Combinational count is pure; no X propagation beyond X inputs.
// CONFIGURATION
//  - Macro POPCOUNT7_STRUCTURAL_EN.
//  - Defined: the combinational count is built from 4 full_adder instances in a carry-save tree:
//    FA1(a0,a1,a2) and FA2(a3,a4,a5) produce two sums and two carries;
//    FA3(s1,s2,a6) gives sum bit0 = w0 and carry c3;
//    FA4(c1,c2,c3) gives w1 = FA4 sum and w2 = FA4 carry.
//  - Undefined: the count is one continuous-assign addition of the seven zero-extended bits.
//  - Both builds must be cycle-for-cycle bit-identical on every output.
// STRUCTURE
//  - Package popcount7_pkg: localparams N_IN=7, CNT_W=3; typedef logic [CNT_W-1:0] cnt_t.
//  - Sub-module full_adder (a,b,cin -> s,cout), used only under POPCOUNT7_STRUCTURAL_EN.
//  - Top holds the combinational count plus one register stage (count reg, out_vld flop).
// TESTING
//  - Reset: rst=1 for 2 cycles with a=7'h7F, in_vld=1 -> w2..w0=000, out_vld=0 throughout.
//  - Walk sequence with in_vld=1 each cycle, one result per cycle, 1-cycle lag;
//    sets listed by index, all other bits 0:
//      none->0; {2,3,4,5}->4; {0,1,2,3,5,6}->6; {0,1,2}->3;
//      {1,2,4}->3; {0,1,2,4,5}->5; {1,3,4}->3; {2,4,5}->3;
//      {0,1,3,4,5}->5; {1,6}->2; {6}->1; all->7.
//  - Hold: accept a with bits {0,1,2} set (-> 011), then in_vld=0 for 3 cycles with a=7'h7F
//    -> outputs stay 011, out_vld=0.
//  - Exhaustive: all 128 values of a streamed back-to-back -> each output equals $countones of the
//    sample one cycle earlier.
//  - Mid-stream reset: rst pulsed while streaming -> 000 next cycle, correct count on the next accepted sample.
//  - Build twice, with and without POPCOUNT7_STRUCTURAL_EN -> identical output traces.

Source files
------------

// File: rtl/popcount7_pkg.sv
// Shared widths and count type for the 7-input registered ones counter.
package popcount7_pkg;
  localparam int N_IN  = 7;
  localparam int CNT_W = 3;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/popcount7_full_adder.sv
// One-bit full adder used by the carry-save build of popcount7_reg.
// Only compiled in when POPCOUNT7_STRUCTURAL_EN is defined.
`ifdef POPCOUNT7_STRUCTURAL_EN
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule
`endif

// File: rtl/popcount7_reg.sv
// Registered 7-input ones counter, 1-cycle latency, synchronous active-high reset.
// POPCOUNT7_STRUCTURAL_EN selects a 4-full-adder carry-save tree over a plain sum.
module popcount7_reg
  import popcount7_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [0:N_IN-1] a,
  input  logic            in_vld,
  output logic            w0,
  output logic            w1,
  output logic            w2,
  output logic            out_vld
);

  cnt_t cnt, cnt_q;
  logic vld_q;

`ifdef POPCOUNT7_STRUCTURAL_EN
  logic s1, c1, s2, c2, s3, c3, s4, c4;

  // Two leaf adders compress six bits; the third folds in a6 to give the LSB,
  // the fourth sums the three weight-2 carries into bits 1 and 2.
  full_adder u_fa1 (.a(a[0]), .b(a[1]), .cin(a[2]), .s(s1), .cout(c1));
  full_adder u_fa2 (.a(a[3]), .b(a[4]), .cin(a[5]), .s(s2), .cout(c2));
  full_adder u_fa3 (.a(s1),   .b(s2),   .cin(a[6]), .s(s3), .cout(c3));
  full_adder u_fa4 (.a(c1),   .b(c2),   .cin(c3),   .s(s4), .cout(c4));

  assign cnt = {c4, s4, s3};
`else
  assign cnt = cnt_t'(a[0]) + cnt_t'(a[1]) + cnt_t'(a[2]) + cnt_t'(a[3])
             + cnt_t'(a[4]) + cnt_t'(a[5]) + cnt_t'(a[6]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_vld;
      if (in_vld) cnt_q <= cnt;
    end
  end

  assign w0      = cnt_q[0];
  assign w1      = cnt_q[1];
  assign w2      = cnt_q[2];
  assign out_vld = vld_q;

endmodule

// File: tb/tb_popcount7_reg.sv
// Scoreboard bench for popcount7_reg: driver queues expected counts, monitor pops on out_vld.
module tb_popcount7_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:6] a;
  logic       in_vld;
  logic       w0, w1, w2, out_vld;

  int total = 0;
  int bad   = 0;

  logic [2:0] q[$];
  logic       chk_en  = 1'b0;
  logic [3:0] chk_val = 4'h0;
  logic       done    = 1'b0;
  logic       fin     = 1'b0;

  popcount7_reg dut (
    .clk(clk), .rst(rst), .a(a), .in_vld(in_vld),
    .w0(w0), .w1(w1), .w2(w2), .out_vld(out_vld)
  );

  always #5 clk = ~clk;

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (out_vld === 1'b1) begin
      total = total + 1;
      if (q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_out_vld: got cnt=%0d with empty scoreboard", {w2, w1, w0});
      end else begin
        logic [2:0] e;
        e = q.pop_front();
        if ({w2, w1, w0} !== e) begin
          bad = bad + 1;
          $display("FAIL count: got %b want %b", {w2, w1, w0}, e);
        end
      end
    end
    if (chk_en) begin
      total = total + 1;
      if ({w2, w1, w0, out_vld} !== chk_val) begin
        bad = bad + 1;
        $display("FAIL state: got cnt=%b vld=%b want cnt=%b vld=%b",
                 {w2, w1, w0}, out_vld, chk_val[3:1], chk_val[0]);
      end
    end
    if (done && !fin) begin
      fin = 1'b1;
      total = total + 1;
      if (q.size() != 0) begin
        bad = bad + 1;
        $display("FAIL drain: %0d results never seen, want 0", q.size());
      end
    end
  end

  // One clock: drive inputs, queue expectation if the sample is accepted,
  // optionally request a direct state check of the outputs after this edge.
  task automatic cyc(input logic r, input logic v, input logic [6:0] bits,
                     input int exp, input logic c, input logic [3:0] cv);
    rst    = r;
    in_vld = v;
    for (int i = 0; i < 7; i++) a[i] = bits[i];
    if (v && !r) q.push_back(3'(exp));
    @(posedge clk);
    chk_en  = c;
    chk_val = cv;
    @(negedge clk);
    #1;
    chk_en = 1'b0;
  endtask

  logic [6:0] walk_v [12] = '{7'h00, 7'h3C, 7'h6F, 7'h07, 7'h16, 7'h37,
                              7'h1A, 7'h34, 7'h3B, 7'h42, 7'h40, 7'h7F};
  int         walk_e [12] = '{0, 4, 6, 3, 3, 5, 3, 3, 5, 2, 1, 7};

  initial begin
    rst = 1'b1; in_vld = 1'b1; a = 7'h7F;
    // Reset with live input: outputs must stay cleared.
    cyc(1, 1, 7'h7F, 0, 1, 4'b0000);
    cyc(1, 1, 7'h7F, 0, 1, 4'b0000);

    // Walk sequence, first sample right after reset release.
    for (int i = 0; i < 12; i++) cyc(0, 1, walk_v[i], walk_e[i], 0, 4'h0);

    // Hold: value 011 must persist while in_vld is low.
    cyc(0, 1, 7'h07, 3, 0, 4'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 7'h7F, 0, 1, 4'b0110);

    // Exhaustive back-to-back stream.
    for (int i = 0; i < 128; i++) cyc(0, 1, 7'(i), $countones(7'(i)), 0, 4'h0);

    // Mid-stream reset: the sample presented with rst is dropped.
    cyc(0, 1, 7'h3F, 6, 0, 4'h0);
    cyc(1, 1, 7'h7F, 0, 1, 4'b0000);
    cyc(0, 1, 7'h15, 3, 0, 4'h0);
    cyc(0, 1, 7'h01, 1, 0, 4'h0);
    cyc(0, 0, 7'h00, 0, 1, 4'b0010);

    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
